cfu_cmd_dispatcher: RTL and testbench
=====================================

Name: cfu_cmd_dispatcher

Overview:
- Sits between the CPU custom-instruction (cmd/rsp) port and two command targets.
- Target 0 is the tinyML accelerator, taking function_id[9]=0. Target 1 is the user custom-instruction slot, taking function_id[9]=1.
- Accepts one command at a time, issues it to the selected target, waits for that target's response and returns it to the CPU.
- A watchdog returns an error response if the target stalls, so the CPU never hangs.

Parameters:
- TIMEOUT_CYCLES, 65536: cycles allowed from entering ISSUE until target response; 0 disables the watchdog.
- ERR_RSP, 32'hDEAD_BEEF: rsp_outputs_0 value returned on timeout.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  CPU command valid
- cmd_function_id  in  10  function ID; bit 9 selects the target
- cmd_inputs_0  in  32  operand 0
- cmd_inputs_1  in  32  operand 1
- cmd_ready  out  1  dispatcher can accept a command
- rsp_valid  out  1  response to CPU valid
- rsp_outputs_0  out  32  response data
- rsp_ready  in  1  CPU accepts response
- t_cmd_function_id  out  10  latched function ID, shared by both targets
- t_cmd_inputs_0  out  32  latched operand 0, shared
- t_cmd_inputs_1  out  32  latched operand 1, shared
- t0_cmd_valid  out  1  command valid to target 0
- t0_cmd_ready  in  1  target 0 accepts command
- t0_rsp_valid  in  1  target 0 response valid
- t0_rsp_outputs_0  in  32  target 0 response data
- t0_rsp_ready  out  1  dispatcher accepts target 0 response
- t1_cmd_valid, t1_cmd_ready, t1_rsp_valid, t1_rsp_outputs_0, t1_rsp_ready: same directions and widths as t0_*, for target 1
- timeout_err  out  1  one-cycle pulse when the watchdog fires
- err_count  out  16  saturating count of timeouts

Behaviour:
- Reset values (async assert, sync release):
  - state=IDLE
  - all valid/ready outputs 0, except cmd_ready=1 (decoded from IDLE)
  - rsp_outputs_0=0, t_cmd_*=0, timeout_err=0, err_count=0, watchdog counter=0
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1, decoded combinationally from state.
  - On cmd_valid: latch function_id and both inputs into t_cmd_*, latch sel=cmd_function_id[9], clear the watchdog counter, go to ISSUE.
- ISSUE:
  - t{sel}_cmd_valid=1, registered; the other target's valid stays 0.
  - On t{sel}_cmd_ready=1 go to WAIT; valid drops the next cycle.
  - t_cmd_* stay stable for the whole command.
- WAIT:
  - t{sel}_rsp_ready=1, decoded from state and sel; the non-selected target's rsp_ready=0.
  - On t{sel}_rsp_valid: latch t{sel}_rsp_outputs_0 into rsp_outputs_0, go to RESP.
- RESP:
  - rsp_valid=1 and rsp_outputs_0 held until rsp_ready=1, then go to IDLE.
  - cmd_ready=0 until IDLE is reached, so no overlap of commands.
- Latency, with command accepted in cycle N:
  - t_cmd_valid is high in N+1.
  - If the target is ready in N+1, WAIT starts in N+2.
  - Target rsp_valid in WAIT cycle M gives rsp_valid in M+1.
  - Back-to-back minimum: a new cmd_valid can be accepted in the cycle after the rsp handshake.
- Watchdog:
  - The counter increments every cycle in ISSUE or WAIT.
  - When it equals TIMEOUT_CYCLES-1 and no completing handshake occurs that cycle:
    - force t{sel}_cmd_valid to 0;
    - load rsp_outputs_0=ERR_RSP;
    - pulse timeout_err for 1 cycle;
    - increment err_count, saturating at 16'hFFFF;
    - go to RESP.
  - TIMEOUT_CYCLES=0: the counter never fires.
- Simultaneous events:
  - A target handshake (cmd accept in ISSUE or rsp in WAIT) in the same cycle as the timeout wins; no error is flagged.
  - Target rsp_valid outside WAIT, or from the non-selected target, is ignored because its rsp_ready is 0.
  - A late response after a timeout is never forwarded.
- Reset mid-operation: all handshakes abort immediately, the FSM returns to IDLE, err_count clears.
- The counter is sized by clog2(TIMEOUT_CYCLES+1) and must not wrap within one command.

Test Plan:
- Basic target 0: cmd fid=10'h005, in0=1, in1=2, target 0 ready at once and rsp 32'h3 two cycles later.
  - Expect t0_cmd_valid 1 cycle, t1_cmd_valid never, rsp_valid=1 with rsp_outputs_0=3.
  - cmd_ready=0 from acceptance until the rsp handshake.
- Basic target 1: fid=10'h201, target 1 returns 32'hA5A5_0001.
  - Expect only t1 handshakes, CPU receives 32'hA5A5_0001.
  - Concurrently, a spurious t0_rsp_valid is ignored (t0_rsp_ready=0).
- Backpressure: the target holds cmd_ready=0 for 5 cycles and the CPU holds rsp_ready=0 for 4 cycles.
  - Expect t_cmd_* and the valid held stable.
  - rsp_outputs_0 held, and exactly one response delivered.
- Timeout with TIMEOUT_CYCLES=16: the target never responds.
  - Expect timeout_err pulse 16 cycles after ISSUE entry, rsp_outputs_0=32'hDEADBEEF, err_count=1.
  - A later t0_rsp_valid is ignored; the next command completes normally.
- Race: target rsp_valid arrives exactly in the timeout cycle.
  - Expect the target data returned, timeout_err=0, err_count unchanged.
- Reset mid-WAIT: assert reset asynchronously.
  - Expect all outputs at reset values immediately, cmd_ready=1 after release.
  - A new command is accepted normally.

Source files
------------

// File: rtl/cfu_cmd_dispatcher.sv
// Single-outstanding dispatcher between the CPU cmd/rsp port and two command
// targets (tinyML accelerator, user slot), with a watchdog error response.
module cfu_cmd_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter logic [31:0] ERR_RSP        = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [9:0]  cmd_function_id,
    input  logic [31:0] cmd_inputs_0,
    input  logic [31:0] cmd_inputs_1,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_outputs_0,
    input  logic        rsp_ready,
    output logic [9:0]  t_cmd_function_id,
    output logic [31:0] t_cmd_inputs_0,
    output logic [31:0] t_cmd_inputs_1,
    output logic        t0_cmd_valid,
    input  logic        t0_cmd_ready,
    input  logic        t0_rsp_valid,
    input  logic [31:0] t0_rsp_outputs_0,
    output logic        t0_rsp_ready,
    output logic        t1_cmd_valid,
    input  logic        t1_cmd_ready,
    input  logic        t1_rsp_valid,
    input  logic [31:0] t1_rsp_outputs_0,
    output logic        t1_rsp_ready,
    output logic        timeout_err,
    output logic [15:0] err_count
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES == 32'd0) ? 1 : $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              sel_r, sel_s;
    logic [CNT_W-1:0]  wdog_r, wdog_s, wdog_inc_s;
    logic              t0_valid_r, t0_valid_s;
    logic              t1_valid_r, t1_valid_s;
    logic [9:0]        fid_r, fid_s;
    logic [31:0]       in0_r, in0_s;
    logic [31:0]       in1_r, in1_s;
    logic [31:0]       rsp_data_r, rsp_data_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              timeout_r, timeout_s;
    logic [15:0]       err_cnt_r, err_cnt_s, err_inc_s;
    logic              sel_cmd_ready_s, sel_rsp_valid_s, wdog_fire_s;
    logic [31:0]       sel_rsp_data_s;

    // Selected-target muxing and saturating increments used by the FSM
    always_comb begin
        sel_cmd_ready_s = sel_r ? t1_cmd_ready : t0_cmd_ready;
        sel_rsp_valid_s = sel_r ? t1_rsp_valid : t0_rsp_valid;
        sel_rsp_data_s  = sel_r ? t1_rsp_outputs_0 : t0_rsp_outputs_0;
        wdog_inc_s      = (wdog_r == CNT_MAX) ? wdog_r : wdog_r + CNT_W'(32'd1);
        err_inc_s       = (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
        // Budget already spent also fires, so a late cmd accept cannot park WAIT forever
        wdog_fire_s     = WDOG_EN && (wdog_r >= CNT_LAST);
    end

    // Next-state and next-register values for the command FSM
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        wdog_s      = wdog_r;
        t0_valid_s  = t0_valid_r;
        t1_valid_s  = t1_valid_r;
        fid_s       = fid_r;
        in0_s       = in0_r;
        in1_s       = in1_r;
        rsp_data_s  = rsp_data_r;
        rsp_valid_s = rsp_valid_r;
        timeout_s   = 1'b0;
        err_cnt_s   = err_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    fid_s      = cmd_function_id;
                    in0_s      = cmd_inputs_0;
                    in1_s      = cmd_inputs_1;
                    sel_s      = cmd_function_id[9];
                    wdog_s     = {CNT_W{1'b0}};
                    t0_valid_s = ~cmd_function_id[9];
                    t1_valid_s = cmd_function_id[9];
                    state_s    = ST_ISSUE;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wdog_s = wdog_inc_s;
                if (sel_cmd_ready_s) begin
                    t0_valid_s = 1'b0;
                    t1_valid_s = 1'b0;
                    state_s    = ST_WAIT;
                end else if (wdog_fire_s) begin
                    t0_valid_s  = 1'b0;
                    t1_valid_s  = 1'b0;
                    rsp_data_s  = ERR_RSP;
                    rsp_valid_s = 1'b1;
                    timeout_s   = 1'b1;
                    err_cnt_s   = err_inc_s;
                    state_s     = ST_RESP;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                wdog_s = wdog_inc_s;
                if (sel_rsp_valid_s) begin
                    rsp_data_s  = sel_rsp_data_s;
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else if (wdog_fire_s) begin
                    rsp_data_s  = ERR_RSP;
                    rsp_valid_s = 1'b1;
                    timeout_s   = 1'b1;
                    err_cnt_s   = err_inc_s;
                    state_s     = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                t0_valid_s  = 1'b0;
                t1_valid_s  = 1'b0;
                rsp_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sel_r       <= 1'b0;
            wdog_r      <= {CNT_W{1'b0}};
            t0_valid_r  <= 1'b0;
            t1_valid_r  <= 1'b0;
            fid_r       <= 10'd0;
            in0_r       <= 32'd0;
            in1_r       <= 32'd0;
            rsp_data_r  <= 32'd0;
            rsp_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            err_cnt_r   <= 16'd0;
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            wdog_r      <= wdog_s;
            t0_valid_r  <= t0_valid_s;
            t1_valid_r  <= t1_valid_s;
            fid_r       <= fid_s;
            in0_r       <= in0_s;
            in1_r       <= in1_s;
            rsp_data_r  <= rsp_data_s;
            rsp_valid_r <= rsp_valid_s;
            timeout_r   <= timeout_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    assign cmd_ready         = (state_r == ST_IDLE);
    assign t0_rsp_ready      = (state_r == ST_WAIT) && !sel_r;
    assign t1_rsp_ready      = (state_r == ST_WAIT) && sel_r;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_outputs_0     = rsp_data_r;
    assign t_cmd_function_id = fid_r;
    assign t_cmd_inputs_0    = in0_r;
    assign t_cmd_inputs_1    = in1_r;
    assign t0_cmd_valid      = t0_valid_r;
    assign t1_cmd_valid      = t1_valid_r;
    assign timeout_err       = timeout_r;
    assign err_count         = err_cnt_r;

endmodule

// File: tb/tb_cfu_cmd_dispatcher.sv
// Randomized self-checking bench for cfu_cmd_dispatcher; expectations come from
// a cycle-budget model of each command (deadline, handshake cycle, error count).
module tb_cfu_cmd_dispatcher;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk, reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [9:0]  cmd_function_id, t_cmd_function_id;
    logic [31:0] cmd_inputs_0, cmd_inputs_1, rsp_outputs_0;
    logic [31:0] t_cmd_inputs_0, t_cmd_inputs_1;
    logic        t0_cmd_valid, t0_cmd_ready, t0_rsp_valid, t0_rsp_ready;
    logic        t1_cmd_valid, t1_cmd_ready, t1_rsp_valid, t1_rsp_ready;
    logic [31:0] t0_rsp_outputs_0, t1_rsp_outputs_0;
    logic        timeout_err;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_pass   = 0;
    int err_model = 0;

    cfu_cmd_dispatcher #(.TIMEOUT_CYCLES(TO), .ERR_RSP(ERR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_function_id(cmd_function_id),
        .cmd_inputs_0(cmd_inputs_0), .cmd_inputs_1(cmd_inputs_1),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
        .rsp_outputs_0(rsp_outputs_0), .rsp_ready(rsp_ready),
        .t_cmd_function_id(t_cmd_function_id),
        .t_cmd_inputs_0(t_cmd_inputs_0), .t_cmd_inputs_1(t_cmd_inputs_1),
        .t0_cmd_valid(t0_cmd_valid), .t0_cmd_ready(t0_cmd_ready),
        .t0_rsp_valid(t0_rsp_valid), .t0_rsp_outputs_0(t0_rsp_outputs_0),
        .t0_rsp_ready(t0_rsp_ready),
        .t1_cmd_valid(t1_cmd_valid), .t1_cmd_ready(t1_cmd_ready),
        .t1_rsp_valid(t1_rsp_valid), .t1_rsp_outputs_0(t1_rsp_outputs_0),
        .t1_rsp_ready(t1_rsp_ready),
        .timeout_err(timeout_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_targets();
        t0_cmd_ready = 1'b0; t0_rsp_valid = 1'b0; t0_rsp_outputs_0 = 32'd0;
        t1_cmd_ready = 1'b0; t1_rsp_valid = 1'b0; t1_rsp_outputs_0 = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        logic [6:0] ctrl;
        ctrl = {cmd_ready, t0_cmd_valid, t1_cmd_valid, t0_rsp_ready, t1_rsp_ready, timeout_err, rsp_valid};
        n_checks++;
        if (ctrl !== 7'b1000000) $display("FAIL %s_ctrl: got %b want %b", tag, ctrl, 7'b1000000);
        else n_pass++;
        n_checks++;
        if ({rsp_outputs_0, t_cmd_function_id, t_cmd_inputs_0, t_cmd_inputs_1, err_count} !== 122'd0)
            $display("FAIL %s_data: rsp=%h fid=%h in0=%h in1=%h errc=%h want all 0", tag,
                     rsp_outputs_0, t_cmd_function_id, t_cmd_inputs_0, t_cmd_inputs_1, err_count);
        else n_pass++;
    endtask

    // One command: target accepts in ISSUE cycle a, responds b cycles into WAIT.
    task automatic run_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                           input int a, input int b, input logic [31:0] rdata,
                           input int hold, input bit spur);
        int done, mins, c;
        bit comp, tv, rr;
        logic sel;
        logic [6:0] ctrl, exp_ctrl;
        logic [5:0] ctrl6;
        logic [31:0] exp_data;
        sel = fid[9];
        // Deadline is cycle TO-1 counted from ISSUE entry; a handshake on the deadline wins
        if (a > int'(TO) - 1) begin comp = 1'b0; done = int'(TO) - 1; end
        else if (a + 1 + b <= int'(TO) - 1) begin comp = 1'b1; done = a + 1 + b; end
        else begin comp = 1'b0; done = int'(TO) - 1; end
        mins = (a < done) ? a : done;
        exp_data = comp ? rdata : ERR;

        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1; cmd_function_id = fid; cmd_inputs_0 = in0; cmd_inputs_1 = in1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_function_id = 10'($urandom); cmd_inputs_0 = $urandom; cmd_inputs_1 = $urandom;
        for (c = 0; c < 200; c++) begin
            if (rsp_valid === 1'b1) break;
            tv = (c <= mins);
            rr = (c > a) && (c <= done);
            exp_ctrl = {1'b0, ~sel & tv, sel & tv, ~sel & rr, sel & rr, 1'b0, 1'b0};
            ctrl = {cmd_ready, t0_cmd_valid, t1_cmd_valid, t0_rsp_ready, t1_rsp_ready, timeout_err, rsp_valid};
            n_checks++;
            if (ctrl !== exp_ctrl) $display("FAIL busy_ctrl c=%0d: got %b want %b", c, ctrl, exp_ctrl);
            else n_pass++;
            n_checks++;
            if ({t_cmd_function_id, t_cmd_inputs_0, t_cmd_inputs_1} !== {fid, in0, in1})
                $display("FAIL t_cmd_hold c=%0d: got %h %h %h want %h %h %h", c,
                         t_cmd_function_id, t_cmd_inputs_0, t_cmd_inputs_1, fid, in0, in1);
            else n_pass++;
            if (sel) begin
                t1_cmd_ready = (c >= a); t1_rsp_valid = (c >= a + 1 + b); t1_rsp_outputs_0 = rdata;
                t0_cmd_ready = spur & 1'($urandom); t0_rsp_valid = spur & 1'($urandom); t0_rsp_outputs_0 = $urandom;
            end else begin
                t0_cmd_ready = (c >= a); t0_rsp_valid = (c >= a + 1 + b); t0_rsp_outputs_0 = rdata;
                t1_cmd_ready = spur & 1'($urandom); t1_rsp_valid = spur & 1'($urandom); t1_rsp_outputs_0 = $urandom;
            end
            @(negedge clk);
        end
        n_checks++;
        if (c !== done + 1) $display("FAIL rsp_latency: got cycle %0d want %0d", c, done + 1);
        else n_pass++;
        n_checks++;
        if (rsp_outputs_0 !== exp_data) $display("FAIL rsp_data: got %h want %h", rsp_outputs_0, exp_data);
        else n_pass++;
        ctrl6 = {timeout_err, t0_cmd_valid, t1_cmd_valid, t0_rsp_ready, t1_rsp_ready, cmd_ready};
        n_checks++;
        if (ctrl6 !== {~comp, 5'b00000}) $display("FAIL resp_entry_ctrl: got %b want %b", ctrl6, {~comp, 5'b00000});
        else n_pass++;
        if (!comp && err_model < 65535) err_model++;

        // Late/stray responses while the CPU stalls must not disturb the held result
        clear_targets();
        t0_rsp_valid = 1'b1; t0_rsp_outputs_0 = ~rdata;
        t1_rsp_valid = 1'b1; t1_rsp_outputs_0 = ~rdata;
        for (int k = 0; k < hold; k++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, timeout_err, cmd_ready, rsp_outputs_0} !== {3'b100, exp_data})
                $display("FAIL rsp_hold k=%0d: got v=%b to=%b rdy=%b d=%h want v=1 to=0 rdy=0 d=%h",
                         k, rsp_valid, timeout_err, cmd_ready, rsp_outputs_0, exp_data);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        clear_targets();
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL post_handshake: got %b want 10", {cmd_ready, rsp_valid});
        else n_pass++;
        n_checks++;
        if (err_count !== 16'(err_model)) $display("FAIL err_count: got %0d want %0d", err_count, err_model);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_basic_t0();
        run_cmd(10'h005, 32'd1, 32'd2, 0, 1, 32'h0000_0003, 0, 1'b0);
    endtask

    task automatic test_basic_t1();
        run_cmd(10'h201, $urandom, $urandom, 0, 1, 32'hA5A5_0001, 1, 1'b1);
    endtask

    task automatic test_backpressure();
        run_cmd(10'h07F, $urandom, $urandom, 5, 2, $urandom, 4, 1'b1);
    endtask

    task automatic test_timeout();
        run_cmd(10'h010, $urandom, $urandom, 0, 100, 32'h1111_2222, 2, 1'b0);
        run_cmd(10'h211, $urandom, $urandom, 18, 0, 32'h3333_4444, 0, 1'b0);
        // Stray response in IDLE after a timeout is never forwarded
        t0_rsp_valid = 1'b1; t0_rsp_outputs_0 = 32'h1111_2222;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, t0_rsp_ready, cmd_ready} !== 3'b001)
                $display("FAIL late_rsp_ignored: got %b want 001", {rsp_valid, t0_rsp_ready, cmd_ready});
            else n_pass++;
        end
        clear_targets();
        run_cmd(10'h012, $urandom, $urandom, 1, 3, 32'h0BAD_F00D, 0, 1'b0);
    endtask

    task automatic test_race();
        run_cmd(10'h020, $urandom, $urandom, 0, 14, 32'hCAFE_0001, 0, 1'b1);
        run_cmd(10'h321, $urandom, $urandom, 14, 0, 32'hCAFE_0002, 1, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        cmd_valid = 1'b1; cmd_function_id = 10'h0AA; cmd_inputs_0 = 32'h5; cmd_inputs_1 = 32'h6;
        @(negedge clk);
        cmd_valid = 1'b0; t0_cmd_ready = 1'b1;
        @(negedge clk);
        t0_cmd_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (t0_rsp_ready !== 1'b1) $display("FAIL mid_wait_entry: got %b want 1", t0_rsp_ready);
        else n_pass++;
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        err_model = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_cmd(10'h2AB, $urandom, $urandom, 2, 2, 32'h7777_0001, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            int a, b, h;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 19)) : int'($urandom_range(0, 14));
            b = int'($urandom_range(0, 10));
            h = int'($urandom_range(0, 3));
            run_cmd(10'($urandom), $urandom, $urandom, a, b, $urandom, h, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_function_id = 10'd0;
        cmd_inputs_0 = 32'd0; cmd_inputs_1 = 32'd0; rsp_ready = 1'b0;
        clear_targets();
        test_reset();
        test_basic_t0();
        test_basic_t1();
        test_backpressure();
        test_timeout();
        test_race();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
